// File: rtl/twos_compliment.sv
// -----------------------------------------------------------------------------
// twos_compliment
//   Bit-serial two's-complement negator. On a start request the operand A is
//   latched, then one bit per clock is produced LSB first through an
//   invert-and-add-one datapath: r = ~a ^ c, c' = ~a & c, with c = 1 at the
//   start. The result bits fill an accumulator from the MSB side, so after
//   WIDTH bits the accumulator holds -A mod 2^WIDTH.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-high reset
//   en      in   1      level request; must stay high through BUSY and DONE
//   A       in   WIDTH  operand, sampled only on the start edge
//   ready   out  1      registered result-valid flag
//   Output  out  WIDTH  registered result; changes only on the completing edge
// -----------------------------------------------------------------------------
module twos_compliment #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] A,
   output logic             ready,
   output logic [WIDTH-1:0] Output
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [WIDTH-1:0]  acc_q,   acc_d;
   logic              carry_q, carry_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              ready_q, ready_d;
   logic [WIDTH-1:0]  out_q,   out_d;

   // Serial invert-and-add-one slice.
   logic             a_bit;
   logic             r_bit;
   logic             carry_nxt;
   logic             last_bit;
   logic [WIDTH-1:0] acc_shifted;

   assign a_bit       = shift_q[0];
   assign r_bit       = ~a_bit ^ carry_q;
   assign carry_nxt   = ~a_bit & carry_q;
   assign acc_shifted = {r_bit, acc_q[WIDTH-1:1]};
   // The WIDTH-th bit is being processed on this edge.
   assign last_bit    = (count_q == CntW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (en) begin
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (!en) begin
               state_d = StIdle;
            end else if (last_bit) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (!en) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      shift_d = shift_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      count_d = count_q;
      ready_d = ready_q;
      out_d   = out_q;
      unique case (state_q)
         StIdle: begin
            ready_d = 1'b0;
            if (en) begin
               shift_d = A;
               acc_d   = '0;
               carry_d = 1'b1;
               count_d = '0;
            end
         end
         StBusy: begin
            if (!en) begin
               // Abort: partial result is dropped, Output keeps its old value.
               ready_d = 1'b0;
               acc_d   = '0;
               count_d = '0;
            end else begin
               shift_d = shift_q >> 1;
               acc_d   = acc_shifted;
               carry_d = carry_nxt;
               count_d = count_q + CntW'(1);
               if (last_bit) begin
                  out_d   = acc_shifted;
                  ready_d = 1'b1;
               end
            end
         end
         StDone: begin
            if (!en) begin
               ready_d = 1'b0;
            end
         end
         default: begin
            ready_d = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         acc_q   <= '0;
         carry_q <= 1'b1;
         count_q <= '0;
         ready_q <= 1'b0;
         out_q   <= '0;
      end else begin
         shift_q <= shift_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         count_q <= count_d;
         ready_q <= ready_d;
         out_q   <= out_d;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      ready  = ready_q;
      Output = out_q;
   end

endmodule

// File: tb/tb_twos_compliment.sv
module tb_twos_compliment;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             en;
   logic [WIDTH-1:0] A;
   logic             ready;
   logic [WIDTH-1:0] Output;

   int n_checks;
   int n_errors;

   logic [WIDTH-1:0] exp_q[$];

   twos_compliment #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .A      (A),
      .ready  (ready),
      .Output (Output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait for one rising edge and step 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one full negation. en must be low on entry. Optionally changes A
   // mid-operation and holds en high for extra edges in DONE.
   task automatic run_op(input logic [WIDTH-1:0] a, input bit change_a,
                         input int hold_extra);
      logic [WIDTH-1:0] prev;
      logic [WIDTH-1:0] exp;
      int               edges;
      bit               got;
      prev = Output;
      A    = a;
      en   = 1'b1;
      exp_q.push_back(WIDTH'(-a));
      edges = 0;
      got   = 1'b0;
      while (edges < 20 && !got) begin
         tick();
         edges++;
         if (change_a && edges == 3) A = 8'h55;
         if (ready) begin
            got = 1'b1;
         end else if (Output !== prev) begin
            check_eq("partial_output", Output, prev);
         end
      end
      check_eq("ready_timeout", got, 1'b1);
      check_eq("latency_edges", edges, WIDTH + 1);
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         check_eq("result", Output, exp);
      end else begin
         check_eq("scoreboard_empty", 1, 0);
         exp = '0;
      end
      for (int i = 0; i < hold_extra; i++) begin
         tick();
         check_eq("hold_ready", ready, 1'b1);
         check_eq("hold_output", Output, exp);
      end
      en = 1'b0;
      tick();
      check_eq("drop_ready", ready, 1'b0);
      check_eq("drop_output", Output, exp);
   endtask

   initial begin
      logic [WIDTH-1:0] prev;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      en  = 1'b0;
      A   = '0;
      #12;
      check_eq("reset_ready", ready, 1'b0);
      check_eq("reset_output", Output, 8'h00);
      rst = 1'b0;
      tick();

      // Basic and boundary operands
      run_op(8'd12, 1'b0, 0);
      run_op(8'h01, 1'b0, 0);
      run_op(8'h00, 1'b0, 0);
      run_op(8'h80, 1'b0, 0);
      run_op(8'hFF, 1'b0, 0);
      run_op(8'h7F, 1'b0, 0);

      // A changes during BUSY: result still from A=12
      run_op(8'd12, 1'b1, 0);

      // Abort mid-BUSY: start edge plus 3 BUSY edges, then drop en
      prev = Output;
      A  = 8'h21;
      en = 1'b1;
      repeat (4) tick();
      en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_eq("abort_ready", ready, 1'b0);
         check_eq("abort_output", Output, prev);
      end
      // Restart with current A
      run_op(8'h21, 1'b0, 0);

      // Asynchronous reset mid-BUSY
      A  = 8'h77;
      en = 1'b1;
      repeat (4) tick();
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_ready", ready, 1'b0);
      check_eq("async_rst_output", Output, 8'h00);
      en = 1'b0;
      #3;
      rst = 1'b0;
      tick();
      check_eq("post_rst_output", Output, 8'h00);
      run_op(8'd3, 1'b0, 0);

      // DONE hold for 5 extra edges
      run_op(8'h5A, 1'b0, 5);

      // A few random operands
      for (int i = 0; i < 6; i++) begin
         run_op(WIDTH'($urandom_range(0, 255)), 1'b0, 0);
      end

      check_eq("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
